// File: rtl/codec_stream_sched.sv
// codec_stream_sched: once per LRCK frame, fetch one stereo sample from two valid/ready
// sources and hold it on the codec DAC inputs. Build macro CODEC_SCHED_MIX_EN adds summing mode.
module codec_stream_sched #(
  parameter int DW            = 24,
  parameter int FETCH_TIMEOUT = 64,
  parameter int UCNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lrck,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DW-1:0]     s0_l,
  input  logic [DW-1:0]     s0_r,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DW-1:0]     s1_l,
  input  logic [DW-1:0]     s1_r,
  input  logic [1:0]        cfg_en,
  input  logic              cfg_rr,
  input  logic              cfg_mute,
  input  logic              cfg_mix,
  output logic [DW-1:0]     dac_l,
  output logic [DW-1:0]     dac_r,
  output logic              dac_update,
  output logic [1:0]        active_src,
  output logic [UCNT_W-1:0] underrun_cnt
);
  localparam int TW = $clog2(FETCH_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, LOAD} state_t;
  state_t state, state_nxt;

  logic          lrck_d, tick, rr_ptr, timeout, wait_exit, uflag, rr_adv;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    valid, req, grant, ready, hs, consumed;
  logic [DW-1:0] fetch_l, fetch_r, nxt_l, nxt_r;

  assign tick    = lrck & ~lrck_d;
  assign valid   = {s1_valid, s0_valid};
  assign req     = valid & cfg_en;
  assign timeout = (tmo_cnt == TW'(FETCH_TIMEOUT - 1));

  // Single grant; on contention the rr pointer decides only when cfg_rr is set.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = (cfg_rr && rr_ptr) ? 2'b10 : 2'b01;
  end

`ifdef CODEC_SCHED_MIX_EN
  logic [1:0]    got;
  logic [DW-1:0] cap0_l, cap0_r, cap1_l, cap1_r;
  logic [DW-1:0] m0_l, m0_r, m1_l, m1_r;
  logic          mix_done;

  function automatic logic [DW-1:0] sat_add(input logic signed [DW-1:0] a,
                                            input logic signed [DW-1:0] b);
    logic signed [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) sat_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else                  sat_add = s[DW-1:0];
  endfunction

  always_comb begin
    ready = '0;
    if (state == WAIT) ready = cfg_mix ? (cfg_en & ~got) : grant;
  end

  assign hs       = ready & valid;
  assign consumed = cfg_mix ? (got | hs) : hs;
  assign mix_done = (cfg_en != 2'b00) && ((consumed & cfg_en) == cfg_en);
  assign wait_exit = (state == WAIT) && ((cfg_mix ? mix_done : |hs) || timeout);
  assign rr_adv   = !cfg_mix && (req == 2'b11) && cfg_rr && |hs;

  // A source that never handshook this frame contributes zero to the sum.
  assign m0_l = hs[0] ? s0_l : (got[0] ? cap0_l : '0);
  assign m0_r = hs[0] ? s0_r : (got[0] ? cap0_r : '0);
  assign m1_l = hs[1] ? s1_l : (got[1] ? cap1_l : '0);
  assign m1_r = hs[1] ? s1_r : (got[1] ? cap1_r : '0);
  assign fetch_l = cfg_mix ? sat_add(m0_l, m1_l) : (hs[1] ? s1_l : s0_l);
  assign fetch_r = cfg_mix ? sat_add(m0_r, m1_r) : (hs[1] ? s1_r : s0_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              got <= '0;
    else if (state != WAIT)  got <= '0;
    else                     got <= got | hs;
  end

  always_ff @(posedge clk) begin
    if (hs[0]) begin
      cap0_l <= s0_l;
      cap0_r <= s0_r;
    end
    if (hs[1]) begin
      cap1_l <= s1_l;
      cap1_r <= s1_r;
    end
  end
`else
  logic unused_mix;
  assign unused_mix = cfg_mix;

  assign ready     = (state == WAIT) ? grant : 2'b00;
  assign hs        = ready & valid;
  assign consumed  = hs;
  assign wait_exit = (state == WAIT) && (|hs || timeout);
  assign rr_adv    = (req == 2'b11) && cfg_rr && |hs;
  assign fetch_l   = hs[1] ? s1_l : s0_l;
  assign fetch_r   = hs[1] ? s1_r : s0_r;
`endif

  assign s0_ready = ready[0];
  assign s1_ready = ready[1];
  assign uflag    = ~|consumed;

  always_comb begin
    nxt_l = dac_l;
    nxt_r = dac_r;
    if (!uflag) begin
      nxt_l = fetch_l;
      nxt_r = fetch_r;
    end else if (cfg_mute) begin
      nxt_l = '0;
      nxt_r = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = WAIT;
      WAIT:    if (wait_exit) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // DAC registers load on the WAIT exit edge so LOAD is the cycle they are visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lrck_d       <= 1'b0;
      rr_ptr       <= 1'b0;
      tmo_cnt      <= '0;
      dac_l        <= '0;
      dac_r        <= '0;
      dac_update   <= 1'b0;
      active_src   <= 2'b00;
      underrun_cnt <= '0;
    end else begin
      state      <= state_nxt;
      lrck_d     <= lrck;
      dac_update <= wait_exit;
      if (state == WAIT && !wait_exit) tmo_cnt <= tmo_cnt + 1'b1;
      else                             tmo_cnt <= '0;
      if (rr_adv) rr_ptr <= ~rr_ptr;
      if (wait_exit) begin
        dac_l      <= nxt_l;
        dac_r      <= nxt_r;
        active_src <= consumed;
        if (uflag && !(&underrun_cnt)) underrun_cnt <= underrun_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_codec_stream_sched.sv
// Self-checking bench for codec_stream_sched: scoreboard of expected DAC words per frame,
// plus a narrow-counter instance that must saturate.
module tb_codec_stream_sched;
  localparam int DW = 24;

  logic clk = 1'b0, rst_n = 1'b0, lrck = 1'b0;
  logic s0_valid = 1'b0, s1_valid = 1'b0;
  logic s0_ready, s1_ready;
  logic [DW-1:0] s0_l = '0, s0_r = '0, s1_l = '0, s1_r = '0;
  logic [1:0] cfg_en = 2'b00;
  logic cfg_rr = 1'b0, cfg_mute = 1'b0, cfg_mix = 1'b0;
  logic [DW-1:0] dac_l, dac_r;
  logic dac_update;
  logic [1:0] active_src;
  logic [15:0] underrun_cnt;

  logic u2_unused_s0_ready, u2_unused_s1_ready, u2_unused_upd;
  logic [DW-1:0] u2_unused_l, u2_unused_r;
  logic [1:0] u2_unused_src;
  logic [1:0] u2_cnt;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [1:0]    src;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0, n_fail = 0;
  int hs_cyc, upd_cyc;
  int ucnt = 0;
  logic mptr = 1'b0;
  logic [DW-1:0] last_l = '0, last_r = '0;

  always #5 clk = ~clk;

  codec_stream_sched #(.DW(DW), .FETCH_TIMEOUT(64), .UCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .lrck(lrck),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_l(s0_l), .s0_r(s0_r),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_l(s1_l), .s1_r(s1_r),
    .cfg_en(cfg_en), .cfg_rr(cfg_rr), .cfg_mute(cfg_mute), .cfg_mix(cfg_mix),
    .dac_l(dac_l), .dac_r(dac_r), .dac_update(dac_update),
    .active_src(active_src), .underrun_cnt(underrun_cnt)
  );

  codec_stream_sched #(.DW(DW), .FETCH_TIMEOUT(64), .UCNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .lrck(lrck),
    .s0_valid(1'b0), .s0_ready(u2_unused_s0_ready), .s0_l(s0_l), .s0_r(s0_r),
    .s1_valid(1'b0), .s1_ready(u2_unused_s1_ready), .s1_l(s1_l), .s1_r(s1_r),
    .cfg_en(2'b00), .cfg_rr(1'b0), .cfg_mute(1'b0), .cfg_mix(1'b0),
    .dac_l(u2_unused_l), .dac_r(u2_unused_r), .dac_update(u2_unused_upd),
    .active_src(u2_unused_src), .underrun_cnt(u2_cnt)
  );

  // One LRCK frame: valid for source i rises d_i cycles after the edge (-1 = never),
  // drops after its handshake, and the source then moves on to a new sample.
  task automatic run_frame(input int d0, input int d1);
    logic p0, p1;
    hs_cyc = -1;
    upd_cyc = -1;
    @(negedge clk);
    lrck = 1'b1;
    if (d0 == 0) s0_valid = 1'b1;
    if (d1 == 0) s1_valid = 1'b1;
    #1;
    p0 = s0_valid & s0_ready;
    p1 = s1_valid & s1_ready;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      if (p0) begin s0_valid = 1'b0; s0_l += 24'h010101; s0_r += 24'h020202; end
      if (p1) begin s1_valid = 1'b0; s1_l += 24'h010101; s1_r += 24'h020202; end
      if (dac_update) begin upd_cyc = i; break; end
      if (i == d0) s0_valid = 1'b1;
      if (i == d1) s1_valid = 1'b1;
      #1;
      p0 = s0_valid & s0_ready;
      p1 = s1_valid & s1_ready;
      if ((p0 || p1) && hs_cyc < 0) hs_cyc = i;
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    lrck = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({dac_l, dac_r} !== '0) begin
      n_fail++; $display("FAIL reset_dac got %h/%h exp 0/0", dac_l, dac_r);
    end
    n_tests++;
    if ({dac_update, active_src, s0_ready, s1_ready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got upd=%b src=%b rdy=%b%b exp all 0",
                         dac_update, active_src, s1_ready, s0_ready);
    end
    n_tests++;
    if (underrun_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_ucnt got %0d exp 0", underrun_cnt);
    end
  endtask

  task automatic test_single();
    exp_t e;
    cfg_en = 2'b01;
    s0_l = 24'h123456;
    s0_r = 24'hABCDEF;
    exp_q.push_back('{l: s0_l, r: s0_r, src: 2'b01});
    run_frame(0, -1);
    e = exp_q.pop_front();
    last_l = e.l; last_r = e.r;
    n_tests++;
    if ({dac_l, dac_r, active_src} !== {e.l, e.r, e.src}) begin
      n_fail++; $display("FAIL single_data got %h/%h src=%b exp %h/%h src=%b",
                         dac_l, dac_r, active_src, e.l, e.r, e.src);
    end
    n_tests++;
    if (hs_cyc !== 1 || upd_cyc !== 2) begin
      n_fail++; $display("FAIL single_latency got hs=%0d upd=%0d exp hs=1 upd=2", hs_cyc, upd_cyc);
    end
    @(negedge clk);
    n_tests++;
    if (dac_update !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse_width got dac_update=%b exp 0", dac_update);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic win;
    cfg_en = 2'b11;
    cfg_rr = 1'b1;
    s1_l = 24'h400000;
    s1_r = 24'h500000;
    for (int f = 0; f < 6; f++) begin
      if (f == 4) cfg_rr = 1'b0;
      win = cfg_rr && mptr;
      if (cfg_rr) mptr = ~mptr;
      if (win) exp_q.push_back('{l: s1_l, r: s1_r, src: 2'b10});
      else     exp_q.push_back('{l: s0_l, r: s0_r, src: 2'b01});
      run_frame(0, 0);
      e = exp_q.pop_front();
      last_l = e.l; last_r = e.r;
      n_tests++;
      if ({dac_l, dac_r, active_src} !== {e.l, e.r, e.src} || hs_cyc !== 1) begin
        n_fail++; $display("FAIL rr_frame%0d got %h/%h src=%b hs=%0d exp %h/%h src=%b hs=1",
                           f, dac_l, dac_r, active_src, hs_cyc, e.l, e.r, e.src);
      end
    end
  endtask

  task automatic test_late_valid();
    exp_t e;
    cfg_en = 2'b01;
    exp_q.push_back('{l: s0_l, r: s0_r, src: 2'b01});
    run_frame(30, -1);
    e = exp_q.pop_front();
    last_l = e.l; last_r = e.r;
    n_tests++;
    if ({dac_l, dac_r, active_src} !== {e.l, e.r, e.src}) begin
      n_fail++; $display("FAIL late_data got %h/%h src=%b exp %h/%h src=%b",
                         dac_l, dac_r, active_src, e.l, e.r, e.src);
    end
    n_tests++;
    if (hs_cyc !== 30 || upd_cyc !== 31 || underrun_cnt !== ucnt[15:0]) begin
      n_fail++; $display("FAIL late_timing got hs=%0d upd=%0d ucnt=%0d exp hs=30 upd=31 ucnt=%0d",
                         hs_cyc, upd_cyc, underrun_cnt, ucnt);
    end
  endtask

  task automatic test_underrun();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      cfg_mute = (k != 0);
      cfg_en   = (k == 2) ? 2'b00 : 2'b01;
      if (cfg_mute) exp_q.push_back('{l: '0, r: '0, src: 2'b00});
      else          exp_q.push_back('{l: last_l, r: last_r, src: 2'b00});
      if (k == 2) run_frame(0, 0);
      else        run_frame(-1, -1);
      ucnt++;
      e = exp_q.pop_front();
      last_l = e.l; last_r = e.r;
      n_tests++;
      if ({dac_l, dac_r, active_src} !== {e.l, e.r, e.src}) begin
        n_fail++; $display("FAIL underrun%0d_data got %h/%h src=%b exp %h/%h src=%b",
                           k, dac_l, dac_r, active_src, e.l, e.r, e.src);
      end
      n_tests++;
      if (upd_cyc !== 65 || hs_cyc !== -1 || underrun_cnt !== ucnt[15:0]) begin
        n_fail++; $display("FAIL underrun%0d_timing got upd=%0d hs=%0d ucnt=%0d exp upd=65 hs=-1 ucnt=%0d",
                           k, upd_cyc, hs_cyc, underrun_cnt, ucnt);
      end
    end
    cfg_mute = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    cfg_en = 2'b01;
    @(negedge clk);
    lrck = 1'b1;
    @(negedge clk);
    s0_valid = 1'b1;
    #1;
    n_tests++;
    if (s0_ready !== 1'b1) begin
      n_fail++; $display("FAIL midwait_ready_before got %b exp 1", s0_ready);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (s0_ready !== 1'b0) begin
      n_fail++; $display("FAIL midwait_ready_async got %b exp 0", s0_ready);
    end
    n_tests++;
    if ({dac_l, dac_r, active_src, underrun_cnt, dac_update} !== '0) begin
      n_fail++; $display("FAIL midwait_outputs got %h/%h src=%b ucnt=%0d upd=%b exp all 0",
                         dac_l, dac_r, active_src, underrun_cnt, dac_update);
    end
    s0_valid = 1'b0;
    lrck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 1'b0; ucnt = 0;
    exp_q.push_back('{l: s0_l, r: s0_r, src: 2'b01});
    run_frame(0, -1);
    e = exp_q.pop_front();
    last_l = e.l; last_r = e.r;
    n_tests++;
    if ({dac_l, dac_r, active_src} !== {e.l, e.r, e.src} || upd_cyc !== 2) begin
      n_fail++; $display("FAIL midwait_resume got %h/%h src=%b upd=%0d exp %h/%h src=%b upd=2",
                         dac_l, dac_r, active_src, upd_cyc, e.l, e.r, e.src);
    end
  endtask

  task automatic test_saturation();
    cfg_en = 2'b00;
    for (int k = 0; k < 5; k++) begin
      run_frame(-1, -1);
      ucnt++;
      n_tests++;
      if (underrun_cnt !== ucnt[15:0]) begin
        n_fail++; $display("FAIL sat_main%0d got %0d exp %0d", k, underrun_cnt, ucnt);
      end
    end
    n_tests++;
    if (u2_cnt !== 2'd3) begin
      n_fail++; $display("FAIL sat_narrow got %0d exp 3", u2_cnt);
    end
  endtask

`ifdef CODEC_SCHED_MIX_EN
  task automatic test_mix();
    exp_t e;
    cfg_mix = 1'b1;
    cfg_en = 2'b11;
    s0_l = 24'h7FFFFF; s1_l = 24'h000001;
    s0_r = 24'h800000; s1_r = 24'hFFFFFF;
    exp_q.push_back('{l: 24'h7FFFFF, r: 24'h800000, src: 2'b11});
    run_frame(0, 0);
    e = exp_q.pop_front();
    n_tests++;
    if ({dac_l, dac_r, active_src} !== {e.l, e.r, e.src}) begin
      n_fail++; $display("FAIL mix_sat got %h/%h src=%b exp %h/%h src=%b",
                         dac_l, dac_r, active_src, e.l, e.r, e.src);
    end
    exp_q.push_back('{l: s1_l, r: s1_r, src: 2'b10});
    run_frame(-1, 0);
    e = exp_q.pop_front();
    n_tests++;
    if ({dac_l, dac_r, active_src} !== {e.l, e.r, e.src} || upd_cyc !== 65) begin
      n_fail++; $display("FAIL mix_single got %h/%h src=%b upd=%0d exp %h/%h src=%b upd=65",
                         dac_l, dac_r, active_src, upd_cyc, e.l, e.r, e.src);
    end
    cfg_mix = 1'b0;
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_late_valid();
    test_underrun();
    test_reset_mid_wait();
    test_saturation();
`ifdef CODEC_SCHED_MIX_EN
    test_mix();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete, n_tests=%0d", n_tests);
    $fatal(1);
  end
endmodule
